// File: rtl/core_pkg.sv
// Shared core types: ROB tag/data widths, load width codes, CDB bundle.
// Used by the load reservation station, the load buffer and CDB producers.
package core_pkg;

   localparam int TAG_W = 6;
   localparam int XLEN  = 32;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } load_width_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
   } cdb_t;

endpackage

// File: rtl/load_reservation_station_if.sv
// Dispatch, CDB and load-buffer signals of the load reservation station.
// master = dispatch/CDB/load-buffer side, slave = the station itself.
interface load_reservation_station_if;
   import core_pkg::*;

   logic             dispatch_valid;
   logic             dispatch_ready;
   logic [XLEN-1:0]  dispatch_base_val;
   logic [TAG_W-1:0] dispatch_base_tag;
   logic [XLEN-1:0]  dispatch_offset;
   logic [2:0]       dispatch_width;
   logic [TAG_W-1:0] dispatch_rob_dest;
   cdb_t             cdb_data;
   logic             lb_full;
   logic             lb_we;
   logic [XLEN-1:0]  lb_addr;
   logic [2:0]       lb_width;
   logic [TAG_W-1:0] lb_rob_dest;

   modport master (
      output dispatch_valid, dispatch_base_val, dispatch_base_tag,
      output dispatch_offset, dispatch_width, dispatch_rob_dest,
      output cdb_data, lb_full,
      input  dispatch_ready, lb_we, lb_addr, lb_width, lb_rob_dest
   );

   modport slave (
      input  dispatch_valid, dispatch_base_val, dispatch_base_tag,
      input  dispatch_offset, dispatch_width, dispatch_rob_dest,
      input  cdb_data, lb_full,
      output dispatch_ready, lb_we, lb_addr, lb_width, lb_rob_dest
   );

endinterface

// File: rtl/load_agu.sv
// Load address generation: base + offset (carry dropped) and a
// natural-alignment check for halfword/word loads.
module load_agu
   import core_pkg::*;
(
   input  logic [XLEN-1:0] base,
   input  logic [XLEN-1:0] offset,
   input  logic [2:0]      width,
   output logic [XLEN-1:0] addr,
   output logic            misaligned
);

   assign addr = base + offset;

   // halfwords need bit 0 clear, words need bits 1:0 clear
   always_comb begin
      misaligned = 1'b0;
      case (width)
         LD_H, LD_HU: misaligned = addr[0];
         LD_W:        misaligned = |addr[1:0];
         default:     misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/load_reservation_station.sv
// In-order load reservation queue: snoops the CDB for pending bases and
// issues head-first to the load buffer. Macro LOAD_RS_MISALIGN_TRAP_EN.
module load_reservation_station
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   load_reservation_station_if.slave bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     exc_valid,
   output logic [TAG_W-1:0]         exc_rob_dest,
   output logic [XLEN-1:0]          exc_addr
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic             valid_q [DEPTH];
   logic             valid_d [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [TAG_W-1:0] tag_d   [DEPTH];
   logic [XLEN-1:0]  val_q   [DEPTH];
   logic [XLEN-1:0]  val_d   [DEPTH];
   logic [XLEN-1:0]  off_q   [DEPTH];
   logic [XLEN-1:0]  off_d   [DEPTH];
   logic [2:0]       wid_q   [DEPTH];
   logic [2:0]       wid_d   [DEPTH];
   logic [TAG_W-1:0] dest_q  [DEPTH];
   logic [TAG_W-1:0] dest_d  [DEPTH];

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW:0]      count_q, count_d;

   logic             lb_we_q, lb_we_d;
   logic [XLEN-1:0]  lb_addr_q, lb_addr_d;
   logic [2:0]       lb_width_q, lb_width_d;
   logic [TAG_W-1:0] lb_rob_dest_q, lb_rob_dest_d;

   logic             exc_valid_q, exc_valid_d;
   logic [TAG_W-1:0] exc_rob_dest_q, exc_rob_dest_d;
   logic [XLEN-1:0]  exc_addr_q, exc_addr_d;

   logic             head_ready;
   logic [XLEN-1:0]  head_addr;
   logic             head_mis;
   logic             do_disp;
   logic             do_issue;
   logic             do_trap;
   logic             deq;

   load_agu u_agu (
      .base       (val_q[head_q]),
      .offset     (off_q[head_q]),
      .width      (wid_q[head_q]),
      .addr       (head_addr),
      .misaligned (head_mis)
   );

   assign head_ready = valid_q[head_q] && (tag_q[head_q] == '0);
   assign bus.dispatch_ready = (count_q < FULL_CNT) && !flush;
   assign do_disp = bus.dispatch_valid && bus.dispatch_ready;

`ifdef LOAD_RS_MISALIGN_TRAP_EN
   assign do_trap  = head_ready && head_mis;
   assign do_issue = head_ready && !head_mis && !bus.lb_full;
`else
   logic unused_mis;
   assign unused_mis = head_mis;
   assign do_trap  = 1'b0;
   assign do_issue = head_ready && !bus.lb_full;
`endif
   assign deq = do_issue || do_trap;

   // next-state: snoop, issue/trap, dispatch, then flush override
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      val_d   = val_q;
      off_d   = off_q;
      wid_d   = wid_q;
      dest_d  = dest_q;
      head_d  = head_q;
      tail_d  = tail_q;
      lb_we_d       = 1'b0;
      lb_addr_d     = lb_addr_q;
      lb_width_d    = lb_width_q;
      lb_rob_dest_d = lb_rob_dest_q;
      exc_valid_d    = 1'b0;
      exc_rob_dest_d = exc_rob_dest_q;
      exc_addr_d     = exc_addr_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && tag_q[i] != '0 &&
             tag_q[i] == bus.cdb_data.tag) begin
            tag_d[i] = '0;
            val_d[i] = bus.cdb_data.value;
         end
      end

      if (deq) begin
         valid_d[head_q] = 1'b0;
         head_d = head_q + PW'(1);
      end
      if (do_issue) begin
         lb_we_d       = 1'b1;
         lb_addr_d     = head_addr;
         lb_width_d    = wid_q[head_q];
         lb_rob_dest_d = dest_q[head_q];
      end
      if (do_trap) begin
         exc_valid_d    = 1'b1;
         exc_rob_dest_d = dest_q[head_q];
         exc_addr_d     = head_addr;
      end

      if (do_disp) begin
         valid_d[tail_q] = 1'b1;
         tag_d[tail_q]   = bus.dispatch_base_tag;
         val_d[tail_q]   = bus.dispatch_base_val;
         off_d[tail_q]   = bus.dispatch_offset;
         wid_d[tail_q]   = bus.dispatch_width;
         dest_d[tail_q]  = bus.dispatch_rob_dest;
         if (bus.cdb_data.tag != '0 &&
             bus.cdb_data.tag == bus.dispatch_base_tag) begin
            tag_d[tail_q] = '0;
            val_d[tail_q] = bus.cdb_data.value;
         end
         tail_d = tail_q + PW'(1);
      end

      count_d = count_q + (PW+1)'(do_disp) - (PW+1)'(deq);

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         lb_we_d     = 1'b0;
         exc_valid_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            val_q[i]   <= '0;
            off_q[i]   <= '0;
            wid_q[i]   <= '0;
            dest_q[i]  <= '0;
         end
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         lb_we_q        <= 1'b0;
         lb_addr_q      <= '0;
         lb_width_q     <= '0;
         lb_rob_dest_q  <= '0;
         exc_valid_q    <= 1'b0;
         exc_rob_dest_q <= '0;
         exc_addr_q     <= '0;
      end else begin
         valid_q        <= valid_d;
         tag_q          <= tag_d;
         val_q          <= val_d;
         off_q          <= off_d;
         wid_q          <= wid_d;
         dest_q         <= dest_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         lb_we_q        <= lb_we_d;
         lb_addr_q      <= lb_addr_d;
         lb_width_q     <= lb_width_d;
         lb_rob_dest_q  <= lb_rob_dest_d;
         exc_valid_q    <= exc_valid_d;
         exc_rob_dest_q <= exc_rob_dest_d;
         exc_addr_q     <= exc_addr_d;
      end
   end

   assign count           = count_q;
   assign bus.lb_we       = lb_we_q;
   assign bus.lb_addr     = lb_addr_q;
   assign bus.lb_width    = lb_width_q;
   assign bus.lb_rob_dest = lb_rob_dest_q;

`ifdef LOAD_RS_MISALIGN_TRAP_EN
   assign exc_valid    = exc_valid_q;
   assign exc_rob_dest = exc_rob_dest_q;
   assign exc_addr     = exc_addr_q;
`else
   logic unused_exc;
   assign unused_exc = exc_valid_q ^ (|exc_rob_dest_q) ^ (|exc_addr_q);
   assign exc_valid    = 1'b0;
   assign exc_rob_dest = '0;
   assign exc_addr     = '0;
`endif

   // widths 011/110/111 are decode errors upstream
   a_width_legal : assert property (
      @(posedge clk) disable iff (!reset_n)
      do_disp |-> (bus.dispatch_width inside {LD_B, LD_H, LD_W, LD_BU, LD_HU})
   );

endmodule

// File: tb/tb_load_reservation_station.sv
// Scoreboard bench for load_reservation_station: expected issues are
// queued at dispatch and compared when lb_we is seen.
module tb_load_reservation_station;
   import core_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0]  addr;
      logic [2:0]       width;
      logic [TAG_W-1:0] dest;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             flush = 1'b0;
   logic [2:0]       count;
   logic             exc_valid;
   logic [TAG_W-1:0] exc_rob_dest;
   logic [XLEN-1:0]  exc_addr;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   load_reservation_station_if bus ();

   load_reservation_station #(.DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .bus          (bus),
      .count        (count),
      .exc_valid    (exc_valid),
      .exc_rob_dest (exc_rob_dest),
      .exc_addr     (exc_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [XLEN-1:0] base,
                           input logic [TAG_W-1:0] tag,
                           input logic [XLEN-1:0] off,
                           input logic [2:0] w,
                           input logic [TAG_W-1:0] dest,
                           input logic [XLEN-1:0] exp_addr,
                           input bit push);
      bus.dispatch_valid    = 1'b1;
      bus.dispatch_base_val = base;
      bus.dispatch_base_tag = tag;
      bus.dispatch_offset   = off;
      bus.dispatch_width    = w;
      bus.dispatch_rob_dest = dest;
      chk("disp_ready", 64'(bus.dispatch_ready), 64'd1);
      if (push) sb.push_back('{exp_addr, w, dest});
      tick();
      bus.dispatch_valid = 1'b0;
   endtask

   // scoreboard: every issue must match the oldest expected load
   always @(negedge clk) begin
      if (reset_n && bus.lb_we) begin
         if (sb.size() == 0) begin
            chk("lb_we_unexpected", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("lb_addr", 64'(bus.lb_addr), 64'(e.addr));
            chk("lb_width", 64'(bus.lb_width), 64'(e.width));
            chk("lb_rob_dest", 64'(bus.lb_rob_dest), 64'(e.dest));
         end
      end
   end

   initial begin
      bus.dispatch_valid    = 1'b0;
      bus.dispatch_base_val = '0;
      bus.dispatch_base_tag = '0;
      bus.dispatch_offset   = '0;
      bus.dispatch_width    = '0;
      bus.dispatch_rob_dest = '0;
      bus.cdb_data          = '0;
      bus.lb_full           = 1'b0;

      // reset state
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_lb_we", 64'(bus.lb_we), 64'd0);
      chk("rst_lb_addr", 64'(bus.lb_addr), 64'd0);
      chk("rst_lb_dest", 64'(bus.lb_rob_dest), 64'd0);
      chk("rst_exc", 64'(exc_valid), 64'd0);
      reset_n = 1'b1;
      tick();

      // ready base: issue one edge after dispatch
      dispatch(32'h1000, 0, 32'h10, 3'b010, 5, 32'h1010, 1);
      chk("t1_we_early", 64'(bus.lb_we), 64'd0);
      tick();
      chk("t1_we", 64'(bus.lb_we), 64'd1);
      tick();
      chk("t1_we_pulse", 64'(bus.lb_we), 64'd0);
      chk("t1_count", 64'(count), 64'd0);

      // base from CDB two cycles later
      dispatch(32'h0, 7, 32'hFFFF_FFFC, 3'b000, 6, 32'h1FFC, 1);
      tick();
      chk("t2_wait", 64'(bus.lb_we), 64'd0);
      bus.cdb_data = '{tag: 7, value: 32'h2000};
      tick();
      bus.cdb_data = '0;
      chk("t2_capture", 64'(bus.lb_we), 64'd0);
      tick();
      chk("t2_issue", 64'(bus.lb_we), 64'd1);

      // same-cycle CDB bypass at dispatch
      bus.cdb_data = '{tag: 7, value: 32'h3000};
      dispatch(32'h0, 7, 32'h8, 3'b100, 8, 32'h3008, 1);
      bus.cdb_data = '0;
      chk("t2b_early", 64'(bus.lb_we), 64'd0);
      tick();
      chk("t2b_issue", 64'(bus.lb_we), 64'd1);
      tick();

      // fill while load buffer full, then drain with wrap
      bus.lb_full = 1'b1;
      dispatch(32'h100, 0, 32'h0, 3'b100, 10, 32'h100, 1);
      dispatch(32'h200, 0, 32'h2, 3'b101, 11, 32'h202, 1);
      dispatch(32'h300, 0, 32'h4, 3'b010, 12, 32'h304, 1);
      dispatch(32'h400, 0, 32'h1, 3'b000, 13, 32'h401, 1);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(bus.dispatch_ready), 64'd0);
      chk("full_no_we", 64'(bus.lb_we), 64'd0);
      tick();
      chk("full_hold", 64'(bus.lb_we), 64'd0);
      bus.dispatch_valid    = 1'b1;
      bus.dispatch_base_val = 32'h500;
      bus.dispatch_base_tag = 0;
      bus.dispatch_offset   = 32'h3;
      bus.dispatch_width    = 3'b001;
      bus.dispatch_rob_dest = 14;
      bus.lb_full = 1'b0;
      tick();
      chk("drain1_we", 64'(bus.lb_we), 64'd1);
      chk("drain1_count", 64'(count), 64'd3);
      chk("fifth_ready", 64'(bus.dispatch_ready), 64'd1);
      sb.push_back('{32'h503, 3'b001, 6'd14});
      tick();
      bus.dispatch_valid = 1'b0;
      chk("drain2_count", 64'(count), 64'd3);
      for (int i = 0; i < 4; i++) begin
         chk("drain_we", 64'(bus.lb_we), 64'd1);
         tick();
      end
      chk("drain_done", 64'(bus.lb_we), 64'd0);
      chk("drain_count", 64'(count), 64'd0);

      // in-order: ready second entry waits behind pending head
      dispatch(32'h0, 9, 32'h40, 3'b010, 20, 32'h140, 1);
      dispatch(32'h500, 0, 32'h0, 3'b010, 21, 32'h500, 1);
      chk("ord_count", 64'(count), 64'd2);
      chk("ord_wait", 64'(bus.lb_we), 64'd0);
      tick();
      chk("ord_wait2", 64'(bus.lb_we), 64'd0);
      bus.cdb_data = '{tag: 9, value: 32'h100};
      tick();
      bus.cdb_data = '0;
      chk("ord_cap", 64'(bus.lb_we), 64'd0);
      tick();
      chk("ord_head", 64'(bus.lb_we), 64'd1);
      tick();
      chk("ord_second", 64'(bus.lb_we), 64'd1);
      tick();
      chk("ord_done", 64'(bus.lb_we), 64'd0);

      // flush with three pending loads
      bus.lb_full = 1'b1;
      dispatch(32'h10, 0, 32'h0, 3'b010, 30, 32'h10, 0);
      dispatch(32'h20, 0, 32'h0, 3'b010, 31, 32'h20, 0);
      dispatch(32'h30, 0, 32'h0, 3'b010, 32, 32'h30, 0);
      chk("fl_count_pre", 64'(count), 64'd3);
      flush = 1'b1;
      #1;
      chk("fl_ready_low", 64'(bus.dispatch_ready), 64'd0);
      tick();
      flush = 1'b0;
      bus.lb_full = 1'b0;
      #1;
      chk("fl_count", 64'(count), 64'd0);
      chk("fl_ready", 64'(bus.dispatch_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_no_we", 64'(bus.lb_we), 64'd0);
      end

      // asynchronous reset mid-stream
      bus.lb_full = 1'b1;
      dispatch(32'h40, 0, 32'h0, 3'b010, 33, 32'h40, 0);
      dispatch(32'h50, 0, 32'h0, 3'b010, 34, 32'h50, 0);
      reset_n = 1'b0;
      #2;
      chk("rs_count", 64'(count), 64'd0);
      chk("rs_we", 64'(bus.lb_we), 64'd0);
      reset_n = 1'b1;
      bus.lb_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rs_no_we", 64'(bus.lb_we), 64'd0);
      end
      chk("rs_ready", 64'(bus.dispatch_ready), 64'd1);

      // misaligned word load
`ifdef LOAD_RS_MISALIGN_TRAP_EN
      dispatch(32'h1000, 0, 32'h2, 3'b010, 3, 32'h1002, 0);
      tick();
      chk("mis_exc", 64'(exc_valid), 64'd1);
      chk("mis_dest", 64'(exc_rob_dest), 64'd3);
      chk("mis_addr", 64'(exc_addr), 64'h1002);
      chk("mis_no_we", 64'(bus.lb_we), 64'd0);
      chk("mis_count", 64'(count), 64'd0);
      tick();
      chk("mis_pulse", 64'(exc_valid), 64'd0);
`else
      dispatch(32'h1000, 0, 32'h2, 3'b010, 3, 32'h1002, 1);
      tick();
      chk("mis_we", 64'(bus.lb_we), 64'd1);
      chk("mis_no_exc", 64'(exc_valid), 64'd0);
      tick();
`endif
      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
